fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h00400000, first fetch address after reset.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low (0 = reset).
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_addr  output  30  word address (fetch_pc[31:2]).
REQ-008 SHALL have port imem_rvalid  input  1  response valid; exactly one cycle after an accepted request.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-010 SHALL have port redirect  input  1  branch/jump/jr redirect from decode.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target.
REQ-012 SHALL have port out_valid  output  1  head entry available.
REQ-013 SHALL have port out_ready  input  1  consumer takes head.
REQ-014 SHALL have port out_inst  output  32  head instruction.
REQ-015 SHALL have port out_pc  output  32  head instruction address.

Function
REQ-016 SHALL hold fetch_pc; accepted request (imem_req & imem_gnt) SHALL advance it by 4, wrapping modulo 2^32.
REQ-017 SHALL assert imem_req only when occupancy + in-flight < DEPTH and not halted (REQ-027); queue SHALL never overflow.
REQ-018 SHALL push {pc, imem_rdata} on imem_rvalid unless squashed; pc is the address that request used.
REQ-019 out_valid SHALL equal occupancy != 0; out_inst/out_pc SHALL come from registered head, no bypass.
REQ-020 Pop on out_valid & out_ready; push and pop in one cycle SHALL leave occupancy unchanged, including when full.
REQ-021 Latency: request accepted cycle N -> push N+1 -> out_valid N+2.
REQ-022 Redirect SHALL, at the next edge: empty the queue, set fetch_pc = redirect_pc, squash any response arriving the following cycle (epoch bit).
REQ-023 Redirect SHALL take priority over push, pop and request in its cycle; a handshake in that cycle counts as consumed.
REQ-024 imem_req SHALL be low in the redirect cycle; fetch from redirect_pc SHALL start the next cycle.
REQ-025 Back-to-back redirects: last one wins; each squashes the prior epoch.

Reset
REQ-026 On reset = 0, immediately: queue empty, out_valid = 0, imem_req = 0, in-flight cleared, epoch = 0, fetch_pc = RESET_PC; out_inst = 0, out_pc = 0. Reset mid-operation SHALL discard all state, including a response due next cycle.

Configuration
REQ-027 With FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL set sticky output fetch_except (1 bit), flush the queue and halt requests until reset; without it, the port SHALL be absent and redirect_pc[1:0] SHALL be ignored.

Structure
REQ-028 Shared package fetch_pkg SHALL hold typedef fetch_entry_t {pc[31:0], inst[31:0]} and constant DEFAULT_RESET_PC.
REQ-029 Circular buffer SHALL be sub-module fq_fifo (head/tail pointers wrapping modulo DEPTH, count, flush input); fetch_queue holds fetch_pc, in-flight and epoch logic.

Verification
REQ-030 Reset release, gnt = 1, out_ready = 1, memory returns addr-tagged data -> out_pc 0x00400000, 0x00400004, ... one per cycle from cycle 2.
REQ-031 out_ready = 0, DEPTH = 4 -> exactly 4 entries queued, imem_req low thereafter; one pop -> exactly one new request.
REQ-032 Redirect to 0x00400100 while a response is in flight -> that response dropped, next out_pc = 0x00400100, no stale entry.
REQ-033 fetch_pc 0xFFFFFFFC, request accepted -> next imem_addr 0, out_pc 0xFFFFFFFC then 0x00000000.
REQ-034 Reset pulsed low with 3 entries queued and one in flight -> out_valid 0 at once; first out_pc 0x00400000 after release.
REQ-035 FETCH_ALIGN_CHECK_EN, redirect_pc 0x00400102 -> fetch_except = 1, imem_req held 0 until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] FETCH_STRIDE     = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetched {pc, inst} entries; flush empties it in one cycle.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop    = pop & ~empty & ~flush;
  assign do_push   = push & (~full | do_pop) & ~flush;
  assign head_data = mem[head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_ONE;
      if (do_pop)  head <= head + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: fetch_pc sequencing, single in-flight request, epoch squash.
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_except and halts fetch.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [29:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_except,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int             CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] PEND_LIMIT = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      inflight_pc;
  logic [31:0]      redirect_target;
  logic             run;
  logic             inflight;
  logic             inflight_epoch;
  logic             epoch;
  logic             halted;
  logic             accepted;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   pending;
  logic             fifo_empty;
  logic             fifo_full;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  logic bad_redirect;

  assign bad_redirect    = redirect & (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
  assign fetch_except    = halted;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (bad_redirect) begin
      halted <= 1'b1;
    end
  end
`else
  logic unused_align;

  assign unused_align    = ^redirect_pc[1:0];
  assign redirect_target = word_align(redirect_pc);
  assign halted          = 1'b0;
`endif

  // Queued entries plus the outstanding response must never exceed the buffer.
  assign pending   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign imem_req  = run & ~halted & ~redirect & ~fifo_full & (pending < PEND_LIMIT);
  assign accepted  = imem_req & imem_gnt;
  assign imem_addr = fetch_pc[31:2];

  assign push       = imem_rvalid & inflight & (inflight_epoch == epoch) & ~redirect;
  assign pop        = out_valid & out_ready & ~redirect;
  assign push_entry = '{pc: inflight_pc, inst: imem_rdata};

  assign out_valid = ~fifo_empty;
  assign out_pc    = out_valid ? head_entry.pc   : 32'h0;
  assign out_inst  = out_valid ? head_entry.inst : 32'h0;

  // run keeps imem_req low until the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run            <= 1'b0;
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= accepted;
      if (redirect) begin
        fetch_pc <= redirect_target;
        epoch    <= ~epoch;
      end else if (accepted) begin
        fetch_pc       <= fetch_pc + FETCH_STRIDE;
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
      end
    end
  end

  fq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(head_entry),
    .count    (count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of accepted fetches plus directed scenario tasks.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic        imem_gnt;
  logic [29:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_except;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int acc_count = 0;
  int pop_count = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t live_e;
  logic         live = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_gnt    (imem_gnt),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_except(fetch_except),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hC0DE_0000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL %s: out_valid timeout, got 0 want 1", tag);
    end
  endtask

  // Memory model: answers every accepted request exactly one cycle later.
  initial begin : responder
    logic        acc;
    logic [29:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clock);
      acc = imem_req && imem_gnt;
      a   = imem_addr;
      @(posedge clock); #1;
      imem_rvalid = acc;
      imem_rdata  = acc ? inst_of(a) : 32'h0;
    end
  end

  // Scoreboard: expected entries queued on accept, compared at the head each cycle.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        live = 1'b0;
      end else begin
        n_cmp++;
        if (out_valid !== (exp_q.size() != 0)) begin
          n_err++;
          $display("FAIL sb_valid: got %b want %b", out_valid, exp_q.size() != 0);
        end
        if (out_valid && exp_q.size() != 0) begin
          n_cmp++;
          if (out_pc !== exp_q[0].pc || out_inst !== exp_q[0].inst) begin
            n_err++;
            $display("FAIL sb_head: got pc %h inst %h want pc %h inst %h",
                     out_pc, out_inst, exp_q[0].pc, exp_q[0].inst);
          end
          if (out_ready && !redirect) begin
            void'(exp_q.pop_front());
            pop_count++;
          end
        end
        if (imem_req) begin
          n_cmp++;
          if (redirect || (exp_q.size() + int'(live) >= DEPTH + int'(out_valid && out_ready))) begin
            n_err++;
            $display("FAIL sb_req: imem_req 1 with redirect %b occupancy %0d, want 0",
                     redirect, exp_q.size() + int'(live));
          end
        end
        if (redirect) exp_q.delete();
        else if (imem_rvalid && live) exp_q.push_back(live_e);
        live = imem_req && imem_gnt;
        if (live) begin
          live_e = '{pc: {imem_addr, 2'b00}, inst: inst_of(imem_addr)};
          acc_count++;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; imem_gnt = 1'b1; out_ready = 1'b1;
    step(3);
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", out_inst); end
  endtask

  task automatic test_stream();
    bit ok;
    logic [31:0] exp_pc;
    @(posedge clock); #1;
    reset = 1'b1;
    wait_valid(8, "stream_first", ok);
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        exp_pc = RPC + 32'(i * 4);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
          n_err++;
          $display("FAIL stream_%0d: got valid %b pc %h want 1 %h", i, out_valid, out_pc, exp_pc);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_fill();
    int a0;
    @(posedge clock); #1;
    out_ready = 1'b0;
    step(12);
    a0 = acc_count;
    step(6);
    n_cmp++; if (acc_count !== a0) begin n_err++; $display("FAIL fill_noreq: got %0d requests want 0", acc_count - a0); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fill_req: got %b want 0", imem_req); end
    n_cmp++; if (exp_q.size() !== DEPTH) begin n_err++; $display("FAIL fill_count: got %0d want %0d", exp_q.size(), DEPTH); end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    a0 = acc_count;
    step(6);
    n_cmp++; if (acc_count - a0 !== 1) begin n_err++; $display("FAIL fill_refill: got %0d requests want 1", acc_count - a0); end
    n_cmp++; if (exp_q.size() !== DEPTH) begin n_err++; $display("FAIL fill_recount: got %0d want %0d", exp_q.size(), DEPTH); end
    out_ready = 1'b1;
    step(8);
  endtask

  task automatic test_redirect();
    bit ok;
    redirect_pc = 32'h0040_0100; redirect = 1'b1;
    @(negedge clock);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %b want 0", imem_req); end
    step(1);
    redirect = 1'b0;
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 30'h0010_0040) begin n_err++; $display("FAIL redir_addr: got %h want 00100040", imem_addr); end
    wait_valid(6, "redir_first", ok);
    if (ok) begin
      n_cmp++; if (out_pc !== 32'h0040_0100) begin n_err++; $display("FAIL redir_pc: got %h want 00400100", out_pc); end
    end
    step(4);
  endtask

  task automatic test_back_to_back();
    bit ok;
    out_ready = 1'b0;
    step(8);
    redirect = 1'b1; redirect_pc = 32'h0050_0000;
    step(1);
    redirect_pc = 32'h0060_0000;
    step(1);
    redirect = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_flush: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 30'h0018_0000) begin n_err++; $display("FAIL b2b_addr: got %h want 00180000", imem_addr); end
    wait_valid(6, "b2b_first", ok);
    if (ok) begin
      n_cmp++; if (out_pc !== 32'h0060_0000) begin n_err++; $display("FAIL b2b_pc: got %h want 00600000", out_pc); end
    end
    step(4);
  endtask

  task automatic test_wrap();
    bit ok;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect = 1'b0;
    @(negedge clock);
    n_cmp++; if (imem_addr !== 30'h3FFF_FFFF || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_addr0: got req %b addr %h want 1 3fffffff", imem_req, imem_addr); end
    @(negedge clock);
    n_cmp++; if (imem_addr !== 30'h0) begin n_err++; $display("FAIL wrap_addr1: got %h want 0", imem_addr); end
    wait_valid(6, "wrap_first", ok);
    if (ok) begin
      n_cmp++; if (out_pc !== 32'hFFFF_FFFC || out_inst !== inst_of(30'h3FFF_FFFF)) begin n_err++; $display("FAIL wrap_pc0: got %h want fffffffc", out_pc); end
      @(negedge clock);
      n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc1: got %h want 0", out_pc); end
    end
    step(4);
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0040_0040;
    step(1);
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (!imem_req && out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_fill: got no full state want req 0 with entries"); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mid_req: got %b want 0", imem_req); end
    step(2);
    reset = 1'b1;
    wait_valid(10, "mid_first", ok);
    if (ok) begin
      n_cmp++; if (out_pc !== RPC || out_inst !== inst_of(RPC[31:2])) begin n_err++; $display("FAIL mid_pc: got %h inst %h want %h", out_pc, out_inst, RPC); end
    end
    step(1);
    out_ready = 1'b1;
    step(6);
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    redirect = 1'b1; redirect_pc = 32'h0040_0102;
    step(1);
    redirect = 1'b0;
    @(negedge clock);
    n_cmp++; if (fetch_except !== 1'b1) begin n_err++; $display("FAIL align_except: got %b want 1", fetch_except); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL align_flush: got %b want 0", out_valid); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL align_halt_%0d: got %b want 0", i, imem_req); end
      @(negedge clock);
    end
    step(1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (fetch_except !== 1'b0) begin n_err++; $display("FAIL align_clear: got %b want 0", fetch_except); end
    step(6);
  endtask
`else
  task automatic test_align();
    bit ok;
    redirect = 1'b1; redirect_pc = 32'h0040_0102;
    step(1);
    redirect = 1'b0;
    @(negedge clock);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 30'h0010_0040) begin n_err++; $display("FAIL align_ignore: got req %b addr %h want 1 00100040", imem_req, imem_addr); end
    wait_valid(6, "align_first", ok);
    if (ok) begin
      n_cmp++; if (out_pc !== 32'h0040_0100) begin n_err++; $display("FAIL align_pc: got %h want 00400100", out_pc); end
    end
    step(4);
  endtask
`endif

  task automatic test_random();
    int p0;
    p0 = pop_count;
    for (int i = 0; i < 300; i++) begin
      imem_gnt  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      redirect  = ($urandom_range(0, 15) == 0);
      redirect_pc = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      step(1);
    end
    redirect = 1'b0; imem_gnt = 1'b1; out_ready = 1'b1;
    step(10);
    n_cmp++; if (pop_count - p0 < 50) begin n_err++; $display("FAIL rand_pops: got %0d want at least 50", pop_count - p0); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
